// File: rtl/registro_arbiter_if.sv
// Requester/register-side bundle for the shared-register write arbiter:
// four request lines with their data, the grant pulse and the register write port.
interface registro_arbiter_if #(
  parameter int WIDTH = 14
);
  logic [3:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] data3;
  logic [3:0]       gnt;
  logic             reg_en;
  logic [WIDTH-1:0] reg_data;

  modport master (
    output req, data0, data1, data2, data3,
    input  gnt, reg_en, reg_data
  );

  modport slave (
    input  req, data0, data1, data2, data3,
    output gnt, reg_en, reg_data
  );
endinterface

// File: rtl/registro_arbiter.sv
// Round-robin arbiter loading one shared register: a request sampled in IDLE gives a
// one-cycle gnt/reg_en pulse after the next edge, then one WRITE cycle; req is ignored in WRITE.
module registro_arbiter #(
  parameter int WIDTH = 14,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  registro_arbiter_if.slave bus,
  output logic [1:0]       last_id,
  output logic [CNT_W-1:0] wr_count,
  output logic             busy
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             en_q, en_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic [WIDTH-1:0] win_data;

  // First set request bit at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    case (win)
      2'd0:    win_data = bus.data0;
      2'd1:    win_data = bus.data1;
      2'd2:    win_data = bus.data2;
      default: win_data = bus.data3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = 4'b0000;
    en_d    = 1'b0;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = 4'b0001 << win;
          en_d    = 1'b1;
          data_d  = win_data;
          last_d  = win;
          busy_d  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy_d  = 1'b0;
        ptr_d   = last_q + 2'd1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      en_q    <= en_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.reg_en   = en_q;
  assign bus.reg_data = data_q;
  assign last_id      = last_q;
  assign wr_count     = cnt_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_registro_arbiter.sv
// Directed bench for registro_arbiter: vector table for contention and pointer order,
// hand sequences for single grant, data stability, async reset and counter wrap.
module tb_registro_arbiter;

  localparam int WIDTH = 14;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [1:0]       last_id;
  logic [CNT_W-1:0] wr_count;
  logic             busy;
  logic [WIDTH-1:0] shreg;
  int               pulses;
  int               tests;
  int               fails;

  registro_arbiter_if #(.WIDTH(WIDTH)) bus ();

  registro_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .last_id  (last_id),
    .wr_count (wr_count),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the shared register the arbiter feeds.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) shreg <= '0;
    else if (bus.reg_en) shreg <= bus.reg_data;
  end

  always @(negedge clk) if (bus.reg_en) pulses++;

  typedef struct {
    logic [3:0]       req;
    logic [3:0]       gnt;
    logic             en;
    logic [WIDTH-1:0] data;
    logic [1:0]       last;
    logic             busy;
    logic [CNT_W-1:0] wc;
  } vec_t;

  vec_t vt [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    tests = 0;
    fails = 0;
    pulses = 0;
    rst_n = 1'b0;
    bus.req = 4'b0000;
    bus.data0 = 14'd1;
    bus.data1 = 14'd2;
    bus.data2 = 14'd3;
    bus.data3 = 14'd4;

    //          req      gnt      en    data   last  busy  wc
    vt[0]  = '{4'b1111, 4'b0001, 1'b1, 14'd1, 2'd0, 1'b1, 8'd0};
    vt[1]  = '{4'b1111, 4'b0000, 1'b0, 14'd1, 2'd0, 1'b0, 8'd1};
    vt[2]  = '{4'b1111, 4'b0010, 1'b1, 14'd2, 2'd1, 1'b1, 8'd1};
    vt[3]  = '{4'b1111, 4'b0000, 1'b0, 14'd2, 2'd1, 1'b0, 8'd2};
    vt[4]  = '{4'b1111, 4'b0100, 1'b1, 14'd3, 2'd2, 1'b1, 8'd2};
    vt[5]  = '{4'b1111, 4'b0000, 1'b0, 14'd3, 2'd2, 1'b0, 8'd3};
    vt[6]  = '{4'b1111, 4'b1000, 1'b1, 14'd4, 2'd3, 1'b1, 8'd3};
    vt[7]  = '{4'b1111, 4'b0000, 1'b0, 14'd4, 2'd3, 1'b0, 8'd4};
    vt[8]  = '{4'b1111, 4'b0001, 1'b1, 14'd1, 2'd0, 1'b1, 8'd4};
    vt[9]  = '{4'b1111, 4'b0000, 1'b0, 14'd1, 2'd0, 1'b0, 8'd5};
    vt[10] = '{4'b0010, 4'b0010, 1'b1, 14'd2, 2'd1, 1'b1, 8'd5};
    vt[11] = '{4'b0000, 4'b0000, 1'b0, 14'd2, 2'd1, 1'b0, 8'd6};
    vt[12] = '{4'b0011, 4'b0001, 1'b1, 14'd1, 2'd0, 1'b1, 8'd6};
    vt[13] = '{4'b0000, 4'b0000, 1'b0, 14'd1, 2'd0, 1'b0, 8'd7};
    vt[14] = '{4'b0010, 4'b0010, 1'b1, 14'd2, 2'd1, 1'b1, 8'd7};
    vt[15] = '{4'b0000, 4'b0000, 1'b0, 14'd2, 2'd1, 1'b0, 8'd8};
    vt[16] = '{4'b0000, 4'b0000, 1'b0, 14'd2, 2'd1, 1'b0, 8'd8};

    #2;
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_en", 32'(bus.reg_en), 32'h0);
    check("rst_data", 32'(bus.reg_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wc", 32'(wr_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      bus.req = vt[i].req;
      tick();
      check($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(vt[i].gnt));
      check($sformatf("v%0d_en", i), 32'(bus.reg_en), 32'(vt[i].en));
      check($sformatf("v%0d_data", i), 32'(bus.reg_data), 32'(vt[i].data));
      check($sformatf("v%0d_last", i), 32'(last_id), 32'(vt[i].last));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].busy));
      check($sformatf("v%0d_wc", i), 32'(wr_count), 32'(vt[i].wc));
    end

    // Single request from requester 2.
    bus.req = 4'b0100;
    bus.data2 = 14'h1ABC;
    tick();
    check("single_gnt", 32'(bus.gnt), 32'h4);
    check("single_en", 32'(bus.reg_en), 32'h1);
    check("single_data", 32'(bus.reg_data), 32'h1ABC);
    check("single_last", 32'(last_id), 32'h2);
    bus.req = 4'b0000;
    tick();
    check("single_en_off", 32'(bus.reg_en), 32'h0);
    check("single_wc", 32'(wr_count), 32'd9);
    check("single_shreg", 32'(shreg), 32'h1ABC);

    // data3 changes after the grant edge must not reach reg_data.
    bus.req = 4'b1000;
    bus.data3 = 14'h0AAA;
    tick();
    check("stab_gnt", 32'(bus.gnt), 32'h8);
    check("stab_data0", 32'(bus.reg_data), 32'h0AAA);
    bus.data3 = 14'h1555;
    bus.req = 4'b0000;
    tick();
    check("stab_data1", 32'(bus.reg_data), 32'h0AAA);
    tick();
    check("stab_data2", 32'(bus.reg_data), 32'h0AAA);
    check("stab_shreg", 32'(shreg), 32'h0AAA);

    // Move the pointer to 2, then reset in the middle of a WRITE.
    bus.req = 4'b0010;
    tick();
    check("pre_gnt1", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b1111;
    tick();
    check("pre_gnt2", 32'(bus.gnt), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(bus.gnt), 32'h0);
    check("arst_en", 32'(bus.reg_en), 32'h0);
    check("arst_data", 32'(bus.reg_data), 32'h0);
    check("arst_last", 32'(last_id), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_wc", 32'(wr_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 256 grants from a clean counter: first one must go to requester 0.
    pulses = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      bus.req = (i == 0) ? 4'b1111 : 4'b0001;
      tick();
      if (i == 0) check("post_rst_gnt", 32'(bus.gnt), 32'h1);
      else if (bus.gnt !== 4'b0001 || bus.reg_en !== 1'b1) bad++;
      bus.req = 4'b0000;
      tick();
      if (bus.reg_en !== 1'b0 || bus.gnt !== 4'b0000) bad++;
      if (i == 127) check("wrap_mid_wc", 32'(wr_count), 32'd128);
    end
    check("wrap_bad", 32'(bad), 32'd0);
    check("wrap_wc", 32'(wr_count), 32'd0);
    tick();
    tick();
    check("wrap_pulses", 32'(pulses), 32'd256);
    check("wrap_idle_en", 32'(bus.reg_en), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/registro_arbiter.md
Name: registro_arbiter

Overview:
Round-robin write arbiter and sequencer for one shared 14-bit enable-gated register (clk, en, 14-bit data in/out).
- Four requesters compete to load a value into that register.
- The block grants one requester at a time, drives the register's enable and data input for exactly one cycle per grant, and tracks fairness and write statistics.
- It sits between the requesting datapath units and the shared register instance.

Parameters:
WIDTH, 14, data width of requester data and register input.
CNT_W, 8, width of the write counter wr_count.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous reset, active-low.
req  input  4  request vector; bit i set means requester i wants a write.
data0  input  WIDTH  requester 0 write data.
data1  input  WIDTH  requester 1 write data.
data2  input  WIDTH  requester 2 write data.
data3  input  WIDTH  requester 3 write data.
gnt  output  4  one-hot grant pulse, registered.
reg_en  output  1  enable to the shared register, registered.
reg_data  output  WIDTH  data to the shared register, registered.
last_id  output  2  index of the most recently granted requester.
wr_count  output  CNT_W  total completed grants, wraps modulo 2^CNT_W.
busy  output  1  high while the FSM is in WRITE.

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, reg_en=0, reg_data=0, last_id=0, wr_count=0, busy=0.
  - Round-robin pointer ptr=0; state=IDLE.
  - Takes effect immediately, including mid-WRITE. The aborted grant is not counted and ptr does not advance.
- FSM states: IDLE, WRITE.
- IDLE:
  - If req==0: stay in IDLE; all outputs hold except gnt=0 and reg_en=0.
  - Else select winner w = first set bit of req, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At that edge: gnt<=onehot(w), reg_en<=1, reg_data<=data_w, last_id<=w, busy<=1, state<=WRITE.
- WRITE (exactly one cycle):
  - gnt<=0, reg_en<=0, busy<=0, ptr<=w+1 mod 4, wr_count<=wr_count+1 (wraps 255->0), state<=IDLE.
  - reg_data holds its value.
  - req is ignored while in WRITE.
- Timing:
  - req sampled at edge k (in IDLE) gives gnt/reg_en high during the cycle after edge k.
  - The shared register captures reg_data at edge k+1.
  - Grant-to-next-grant throughput is 2 cycles.
- Handshake:
  - The requester sees gnt[i]=1 for one cycle and must deassert req[i] at the following edge.
  - A req held high is re-arbitrated normally. Round-robin order still serves the other requesters first.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,… Each requester waits at most 3 grants (6 cycles) after being eligible.
- data_i is sampled only at the grant edge. Changes at any other time are ignored.
- gnt is always one-hot or zero. reg_en equals OR of gnt.

Test Plan:
- Reset: drive rst_n=0 mid-WRITE with req=4'b1111 → outputs clear within the same cycle (no clock edge needed); wr_count=0. After release, the first grant goes to requester 0.
- Single request: req=4'b0100, data2=14'h1ABC → one cycle later gnt=4'b0100, reg_en=1, reg_data=14'h1ABC, last_id=2. Next cycle reg_en=0, wr_count=1; the register output reads 14'h1ABC.
- Full contention: req=4'b1111 held continuously, data_i=i+1 → gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001. reg_data sequence 1,2,3,4,1.
- Pointer skip: after a grant to requester 1, apply req=4'b0011 → requester 0 is granted (search order 2,3,0,1). Then apply req=4'b0010 → requester 1 is granted.
- Data stability: change data3 on the cycle after gnt[3] → reg_data keeps the value sampled at the grant edge.
- Counter wrap: perform 256 single grants → wr_count returns to 0; no spurious reg_en pulses occur.
